mvm_param_engine: RTL
=====================

# mvm_param_engine

- Parametrised signed matrix-vector multiplier: loads a K×K matrix A and a K-vector x, computes y = A·x with P parallel MAC lanes, and streams y out.
- Successor to the fixed k/p/b/g MVM generator outputs, generalised in dimension, lane count and width.
- Adds valid/ready handshakes on both the input and output streams, and optional output saturation.
- Sits between the host load/readout logic and any downstream consumer of y.

## Interface
- K, 8, matrix/vector dimension; must be ≥2 and a power of two.
- P, 2, parallel MAC lanes; must divide K.
- B, 8, signed input element width; output width OW = 2·B.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clock clk.
- loadMatrix  in  1  request to load A (K·K elements, row-major); sampled in IDLE only.
- loadVector  in  1  request to load x (K elements); sampled in IDLE only.
- start  in  1  request to compute y = A·x; sampled in IDLE only.
- data_in  in  B  signed element; accepted when in_valid && in_ready.
- in_valid  in  1  data_in valid.
- in_ready  out  1  high in LOAD_A/LOAD_X only.
- data_out  out  OW  signed y element, y[0] first.
- out_valid  out  1  data_out valid.
- out_ready  in  1  consumer accepts data_out.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse after the last y element is accepted.

## Operation
- States: IDLE, LOAD_A, LOAD_X, COMPUTE, OUTPUT.
- IDLE priority: start > loadMatrix > loadVector; other requests in the same cycle are dropped.
- LOAD_A:
  - Counts accepted beats 0..K·K−1.
  - Element (r,c) is written to bank r mod P at address (r/P)·K + c.
  - Returns to IDLE on the cycle the last beat is accepted. in_valid gaps only stall the count.
- LOAD_X: counts K accepted beats into the x memory, then returns to IDLE.
- COMPUTE:
  - K/P row groups, processed in order. Group g covers rows g·P..g·P+P−1; lane i computes row g·P+i.
  - Per group: K read cycles (column j = 0..K−1). Each lane multiplies a·x into a registered 2B product, then accumulates into an ACC_W = 2B+log2(K) accumulator.
  - The accumulator clears at the start of each group. The P results are written to y memory at addresses g·P+i.
- Final conversion ACC_W → OW: truncation (wrap) or saturation, per Configuration.
- OUTPUT:
  - Streams y[0..K−1]. data_out is held stable while out_valid && !out_ready.
  - After the K-th accepted beat: done = 1 for one cycle, then state = IDLE.
- Memories are not cleared by reset. Contents persist across reset and across runs; start without reload reuses the stored A and x.
- start issued before any load produces undefined y values but a correct handshake sequence and beat count.

## Timing
- Reset values: in_ready 0, out_valid 0, busy 0, done 0, data_out 0. All counters are 0 and state = IDLE.
- Reset mid-operation: next cycle state = IDLE and all outputs at reset values. A partially written y is discarded.
- Request sampled in IDLE at cycle t: the new state is active at t+1.
- COMPUTE group duration: K+3 cycles (K reads, +1 memory read latency, +1 multiply register, +1 accumulate/write).
- COMPUTE total: (K/P)·(K+3) cycles. For K=4, P=2: 14 cycles.
- OUTPUT:
  - First cycle is a y-memory prefetch; out_valid rises on the second OUTPUT cycle.
  - Once valid, one beat is delivered per cycle while out_ready stays high.
- done is registered and rises the cycle after the last out_valid && out_ready.
- Loads: with in_valid held high, LOAD_A lasts K·K cycles and LOAD_X lasts K cycles.

## Configuration
- MVM_SAT_EN defined:
  - Accumulator results above 2^(OW−1)−1 clamp to 2^(OW−1)−1.
  - Results below −2^(OW−1) clamp to −2^(OW−1).
- MVM_SAT_EN undefined: data_out is the low OW bits of the accumulator (two's-complement wrap).
- Internal accumulation is ACC_W wide in both cases.

## Structure
- Package mvm_pkg holds:
  - the state enum type;
  - localparam helpers for ACC_W, address widths (log2(K·K/P), log2(K)) and the saturation limits;
  - the sat/trunc conversion function.
- Sub-module mvm_mac_lane (one per P):
  - Inputs: registered product stage, clear_acc, en.
  - Output: ACC_W accumulator.
- Top level contains the FSM, counters, banked A memory, x memory and y memory.

## Test plan
All scenarios use K=4, P=2, B=8.
1. A = identity, x = [1,2,3,4], out_ready = 1 → y = [1,2,3,4]; done pulses one cycle after beat 4; busy then falls.
2. A all −128, x all −128 (accumulated sum 65536):
   - without MVM_SAT_EN → y = [0,0,0,0];
   - with MVM_SAT_EN → y = [32767,32767,32767,32767].
3. A rows [1,−1,2,0],[0,3,0,−2],[5,5,5,5],[−4,0,0,1]; x = [2,−3,1,4] → y = [7,−17,20,−4].
4. Same as 3, with in_valid gaps every other cycle during loads → identical y; load count is unaffected by gaps.
5. out_ready low for 3 cycles while y[1] is valid → data_out holds −17 throughout; no beat is lost or duplicated.
6. Reset asserted 5 cycles into COMPUTE → next cycle outputs are at reset values and state = IDLE; a following start without reload → y = [7,−17,20,−4].

Source files
------------

// File: rtl/mvm_pkg.sv
// Shared types and width/saturation helpers for the matrix-vector engine.
// Define MVM_SAT_EN to clamp results instead of wrapping them.
package mvm_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoadA,
        StLoadX,
        StCompute,
        StOutput
    } state_e;

    localparam int unsigned KDefault = 8;
    localparam int unsigned PDefault = 2;
    localparam int unsigned BDefault = 8;

    function automatic int unsigned acc_width(input int unsigned k, input int unsigned b);
        return 2 * b + $clog2(k);
    endfunction

    function automatic int unsigned a_addr_width(input int unsigned k, input int unsigned p);
        return $clog2(k * k / p);
    endfunction

    function automatic int unsigned x_addr_width(input int unsigned k);
        return $clog2(k);
    endfunction

    localparam int unsigned AccWDefault = acc_width(KDefault, BDefault);

    function automatic longint sat_max(input int unsigned ow);
        return (longint'(1) << (ow - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int unsigned ow);
        return -(longint'(1) << (ow - 1));
    endfunction

    // Result is a sign-extended value; callers keep the low ow bits.
    function automatic longint conv_acc(input longint acc, input int unsigned ow);
`ifdef MVM_SAT_EN
        if (acc > sat_max(ow)) begin
            return sat_max(ow);
        end else if (acc < sat_min(ow)) begin
            return sat_min(ow);
        end
        return acc;
`else
        return (acc <<< (64 - ow)) >>> (64 - ow);
`endif
    endfunction

endpackage

// File: rtl/mvm_mac_lane.sv
// One MAC lane: registered a*x product feeding a clearable wide accumulator.
module mvm_mac_lane #(
    parameter int unsigned B     = 8,
    parameter int unsigned ACC_W = 19
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [B-1:0]     a_i,
    input  logic signed [B-1:0]     x_i,
    input  logic                    en_i,
    input  logic                    clear_acc_i,
    output logic signed [ACC_W-1:0] acc_o
);

    localparam int unsigned PW = 2 * B;

    logic signed [PW-1:0]    prod_d, prod_q;
    logic signed [ACC_W-1:0] acc_d, acc_q;

    always_comb begin
        prod_d = PW'(a_i) * PW'(x_i);
        acc_d  = acc_q;
        if (clear_acc_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + {{(ACC_W - PW){prod_q[PW-1]}}, prod_q};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prod_q <= '0;
            acc_q  <= '0;
        end else begin
            prod_q <= prod_d;
            acc_q  <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/mvm_param_engine.sv
// Parametrised signed y = A*x engine with P MAC lanes and valid/ready streams.
// Output conversion saturates when MVM_SAT_EN is defined, otherwise wraps.
module mvm_param_engine
    import mvm_pkg::*;
#(
    parameter int unsigned K = 8,
    parameter int unsigned P = 2,
    parameter int unsigned B = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                loadMatrix,
    input  logic                loadVector,
    input  logic                start,
    input  logic signed [B-1:0] data_in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [2*B-1:0]      data_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                done
);

    localparam int unsigned OW     = 2 * B;
    localparam int unsigned ACC_W  = acc_width(K, B);
    localparam int unsigned GROUPS = K / P;
    localparam int unsigned ADEPTH = K * K / P;
    localparam int unsigned AAW    = a_addr_width(K, P);
    localparam int unsigned XAW    = x_addr_width(K);
    localparam int unsigned BW     = (P > 1) ? $clog2(P) : 1;
    localparam int unsigned CW     = $clog2(K * K + 1);

    state_e           state_d, state_q;
    logic [CW-1:0]    cnt_d, cnt_q;
    logic [CW-1:0]    grp_d, grp_q;
    logic [OW-1:0]    data_out_d, data_out_q;
    logic             out_valid_d, out_valid_q;
    logic             done_d, done_q;

    logic signed [B-1:0]  a_mem [P][ADEPTH];
    logic signed [B-1:0]  x_mem [K];
    logic [OW-1:0]        y_mem [K];
    logic signed [B-1:0]  x_rd_q;

    logic signed [ACC_W-1:0] lane_acc [P];
    logic [OW-1:0]           y_conv   [P];

    logic [31:0]     beat, row;
    logic [BW-1:0]   a_wbank;
    logic [AAW-1:0]  a_waddr, a_raddr;
    logic [XAW-1:0]  x_idx;
    logic            a_we, x_we, y_we, acc_en, acc_clr;

    // Row-major beat -> (row, col); rows interleave across banks.
    assign beat    = 32'(cnt_q);
    assign row     = beat / K;
    assign a_wbank = BW'(row % P);
    assign a_waddr = AAW'((row / P) * K + beat % K);
    assign a_raddr = AAW'(32'(grp_q) * K + beat);
    assign x_idx   = XAW'(cnt_q);

    assign a_we    = (state_q == StLoadA) && in_valid;
    assign x_we    = (state_q == StLoadX) && in_valid;
    assign y_we    = (state_q == StCompute) && (cnt_q == CW'(K + 2));
    assign acc_clr = (state_q == StCompute) && (cnt_q == '0);
    assign acc_en  = (state_q == StCompute) && (cnt_q >= CW'(2)) && (cnt_q <= CW'(K + 1));

    for (genvar gi = 0; gi < P; gi++) begin : g_lane
        logic signed [B-1:0] a_rd_q;

        always_ff @(posedge clk) begin
            a_rd_q <= a_mem[gi][a_raddr];
        end

        mvm_mac_lane #(
            .B    (B),
            .ACC_W(ACC_W)
        ) u_lane (
            .clk        (clk),
            .reset      (reset),
            .a_i        (a_rd_q),
            .x_i        (x_rd_q),
            .en_i       (acc_en),
            .clear_acc_i(acc_clr),
            .acc_o      (lane_acc[gi])
        );

        assign y_conv[gi] = OW'(conv_acc(longint'(lane_acc[gi]), OW));
    end

    // Storage is deliberately not reset so A and x survive across runs.
    always_ff @(posedge clk) begin
        if (a_we) begin
            a_mem[a_wbank][a_waddr] <= data_in;
        end
        if (x_we) begin
            x_mem[x_idx] <= data_in;
        end
        if (y_we && !reset) begin
            for (int i = 0; i < P; i++) begin
                y_mem[XAW'(32'(grp_q) * P + 32'(i))] <= y_conv[i];
            end
        end
        x_rd_q <= x_mem[x_idx];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grp_d       = grp_q;
        data_out_d  = data_out_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                grp_d = '0;
                if (start) begin
                    state_d = StCompute;
                end else if (loadMatrix) begin
                    state_d = StLoadA;
                end else if (loadVector) begin
                    state_d = StLoadX;
                end
            end
            StLoadA, StLoadX: begin
                if (in_valid) begin
                    if (((state_q == StLoadA) && (cnt_q == CW'(K * K - 1))) ||
                        ((state_q == StLoadX) && (cnt_q == CW'(K - 1)))) begin
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StCompute: begin
                if (cnt_q == CW'(K + 2)) begin
                    cnt_d = '0;
                    if (grp_q == CW'(GROUPS - 1)) begin
                        grp_d   = '0;
                        state_d = StOutput;
                    end else begin
                        grp_d = grp_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StOutput: begin
                // cnt_q is the index of the next y element to prefetch.
                if (!out_valid_q) begin
                    data_out_d  = y_mem[0];
                    out_valid_d = 1'b1;
                    cnt_d       = CW'(1);
                end else if (out_ready) begin
                    if (cnt_q == CW'(K)) begin
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                        cnt_d       = '0;
                        state_d     = StIdle;
                    end else begin
                        data_out_d = y_mem[x_idx];
                        cnt_d      = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            grp_q       <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grp_q       <= grp_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign in_ready  = (state_q == StLoadA) || (state_q == StLoadX);
    assign busy      = (state_q != StIdle);
    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;

endmodule
